key_entry_decoder: RTL and testbench
====================================

# key_entry_decoder

Consumes the debounced, mode-split key levels produced by the button manager (`KEY_Reg` for value entry, `CMD_Reg` for commands) and turns them into terminal events. It detects press edges, builds a BCD product code one digit at a time, and emits ENTER/CANCEL/PAY/CLEAR_SALE events to the sale controller over a valid/ready handshake. It sits between the button manager and the sale-terminal control FSM.

## Interface
- `DIGITS`, default 3: number of BCD digits in a product code (1..8).
- `CLOCK_50` in 1: system clock. All logic is on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `KEY_Reg` in 4: entry-key levels, 1 = pressed.
  - [0] digit up
  - [1] digit down
  - [2] commit digit
  - [3] backspace
- `CMD_Reg` in 4: command-key levels, 1 = pressed.
  - [0] ENTER
  - [1] CANCEL
  - [2] PAY
  - [3] CLEAR_SALE
- `CUR_DIGIT` out 4: BCD digit currently being edited, for display.
- `CODE` out 4*DIGITS: committed digits. The newest digit is in [3:0].
- `DIGIT_CNT` out clog2(DIGITS+1): number of committed digits.
- `EVT_VALID` out 1: event pending.
- `EVT_TYPE` out 2: event type. 0 ENTER, 1 CANCEL, 2 PAY, 3 CLEAR_SALE.
- `EVT_CODE` out 4*DIGITS: code attached to the event. It is meaningful for ENTER and is zero for all other types.
- `EVT_READY` in 1: consumer accepts the event.

## Operation

**Reset.** All outputs and internal registers are 0. The state is IDLE. The previous-level registers are 0.

**Edge detection.**
- `KEY_Reg` and `CMD_Reg` are each registered once.
- A press on key i is a rising edge: `X[i]` is 1 now and was 0 last cycle.
- Mode-switch guard: a KEY edge on bit i is ignored if `CMD_Reg[i]` was 1 last cycle. A CMD edge on bit i is ignored if `KEY_Reg[i]` was 1 last cycle. Toggling SW while a key is held therefore produces no press.
- If several edges occur in one cycle, only the lowest-index edge is acted on. CMD edges take precedence over KEY edges. All other edges are dropped.

**States.** There are two states: IDLE and HOLD.

In IDLE, KEY presses act as follows:
- Up: `CUR_DIGIT` = (`CUR_DIGIT`+1) mod 10, so 9 wraps to 0.
- Down: `CUR_DIGIT` = (`CUR_DIGIT`+9) mod 10, so 0 wraps to 9.
- Commit:
  - If `DIGIT_CNT` < DIGITS: `CODE` = {`CODE` shifted left by 4, `CUR_DIGIT`}, `DIGIT_CNT`+1, `CUR_DIGIT` = 0.
  - If the code is full: no-op.
- Backspace:
  - If `DIGIT_CNT` > 0: `CODE` is shifted right by 4 with zero fill, `DIGIT_CNT`-1, `CUR_DIGIT` = 0.
  - Otherwise only `CUR_DIGIT` = 0.

In IDLE, CMD presses load the event registers, set `EVT_VALID`, and go to HOLD:
- ENTER:
  - If `DIGIT_CNT` = 0: ignored, no event.
  - Otherwise: `EVT_CODE` = `CODE`, then `CODE`, `DIGIT_CNT` and `CUR_DIGIT` are cleared.
- CANCEL: the entry is cleared and the event is emitted.
- PAY: the event is emitted and the entry is preserved.
- CLEAR_SALE: the entry is cleared and the event is emitted.

In HOLD:
- All presses are dropped, both KEY and CMD.
- `EVT_VALID`, `EVT_TYPE` and `EVT_CODE` hold stable until the handshake completes.
- On a clock edge with `EVT_VALID` and `EVT_READY` both 1, the event is consumed: `EVT_VALID` goes to 0, `EVT_CODE` to 0, and the state returns to IDLE.

**Reset mid-operation.** Asserting `RESET` in any state immediately clears everything, including a pending event. No event is replayed.

## Timing
- A press sampled at clock edge k updates `CUR_DIGIT`, `CODE` and `DIGIT_CNT`, or raises `EVT_VALID`, with visibility after edge k+1. This is one cycle of latency from the sampled input.
- The handshake completes on the edge where `EVT_VALID` and `EVT_READY` are both 1. `EVT_VALID` is 0 after that edge.
- `EVT_READY` held permanently high gives a one-cycle `EVT_VALID` pulse per event.
- A press arriving on the same edge as the acceptance is still in HOLD and is dropped. The first press that can be acted on is sampled one edge later.
- Throughput is at most one event per 2 cycles.
- `EVT_READY` while `EVT_VALID` = 0 has no effect.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- A shared package `sale_terminal_pkg` holds:
  - the `EVT_TYPE` encodings (`EVT_ENTER`=0, `EVT_CANCEL`=1, `EVT_PAY`=2, `EVT_CLEAR_SALE`=3);
  - the key-bit indices;
  - the state encoding (IDLE=0, HOLD=1).
- Sub-module `rise_detect`, 4 bits wide, is instantiated twice, once for `KEY_Reg` and once for `CMD_Reg`. It provides registered previous levels, the edge vector and the previous-level output used by the cross-group guard.

## Test plan
1. **Up-count wrap.** After reset, press Up ×11 → `CUR_DIGIT`=1. Then press Down ×2 → `CUR_DIGIT`=9.
2. **Entry and ENTER.** With DIGITS=3 and `EVT_READY`=1, enter digits 4, 0, 7 via Up/Commit, then press ENTER → exactly one cycle of `EVT_VALID`, `EVT_TYPE`=0, `EVT_CODE`=12'h407. Afterwards `CODE`=0 and `DIGIT_CNT`=0.
3. **Full and backspace.** Commit a 4th digit on a full 12'h123 → `CODE` stays 12'h123. Backspace → `CODE`=12'h012, `DIGIT_CNT`=2. ENTER with `DIGIT_CNT`=0 → no `EVT_VALID`.
4. **Backpressure.** With `EVT_READY`=0, press PAY → `EVT_VALID` held for 20 cycles, `EVT_TYPE`=2 stable, entry preserved. A CANCEL pressed during the hold is dropped. Raising `EVT_READY` → `EVT_VALID` goes low the next cycle and only one event is seen.
5. **Simultaneous and mode switch.** A single-cycle rise of `CMD_Reg`=4'b0110 → only CANCEL is emitted. With `KEY_Reg[0]` held, switch it to `CMD_Reg[0]` in the next cycle → no ENTER and no `CUR_DIGIT` change.
6. **Reset mid-event.** Assert `RESET` asynchronously while in HOLD with `EVT_VALID`=1 → all outputs are 0 immediately, and no event appears after release.

Source files
------------

// File: rtl/sale_terminal_pkg.sv
// rtl/sale_terminal_pkg.sv - shared encodings and BCD helpers for the sale terminal
package sale_terminal_pkg;

    localparam logic [1:0] EVT_ENTER      = 2'd0;
    localparam logic [1:0] EVT_CANCEL     = 2'd1;
    localparam logic [1:0] EVT_PAY        = 2'd2;
    localparam logic [1:0] EVT_CLEAR_SALE = 2'd3;

    localparam logic [1:0] KEY_UP     = 2'd0;
    localparam logic [1:0] KEY_DOWN   = 2'd1;
    localparam logic [1:0] KEY_COMMIT = 2'd2;
    localparam logic [1:0] KEY_BACK   = 2'd3;

    localparam logic [1:0] CMD_ENTER      = 2'd0;
    localparam logic [1:0] CMD_CANCEL     = 2'd1;
    localparam logic [1:0] CMD_PAY        = 2'd2;
    localparam logic [1:0] CMD_CLEAR_SALE = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Lowest set bit wins; callers only use the result when the vector is non-zero.
    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] bcd_up(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_down(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registers a level vector and flags its rising edges
module rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] now_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q  <= '0;
            prev_q <= '0;
        end else begin
            now_q  <= level;
            prev_q <= now_q;
        end
    end

    assign prev = prev_q;
    assign rise = now_q & ~prev_q;

endmodule

// File: rtl/key_entry_decoder.sv
// rtl/key_entry_decoder.sv - turns key/command presses into BCD code entry and terminal events
module key_entry_decoder
    import sale_terminal_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic [3:0]                   KEY_Reg,
    input  logic [3:0]                   CMD_Reg,
    output logic [3:0]                   CUR_DIGIT,
    output logic [4*DIGITS-1:0]          CODE,
    output logic [$clog2(DIGITS+1)-1:0]  DIGIT_CNT,
    output logic                         EVT_VALID,
    output logic [1:0]                   EVT_TYPE,
    output logic [4*DIGITS-1:0]          EVT_CODE,
    input  logic                         EVT_READY
);

    localparam int CODE_W = 4 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    logic [3:0] key_prev, key_rise;
    logic [3:0] cmd_prev, cmd_rise;
    logic [3:0] key_act, cmd_act;
    logic [1:0] key_idx, cmd_idx;

    logic [0:0]        state_q;
    logic [3:0]        cur_q;
    logic [CODE_W-1:0] code_q;
    logic [CW-1:0]     cnt_q;
    logic              valid_q;
    logic [1:0]        type_q;
    logic [CODE_W-1:0] evt_code_q;

    rise_detect #(.WIDTH(4)) u_key_edge (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .level (KEY_Reg),
        .prev  (key_prev),
        .rise  (key_rise)
    );

    rise_detect #(.WIDTH(4)) u_cmd_edge (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .level (CMD_Reg),
        .prev  (cmd_prev),
        .rise  (cmd_rise)
    );

    // A level that migrates between groups on a mode switch must not count as a press.
    always_comb begin
        key_act = key_rise & ~cmd_prev;
        cmd_act = cmd_rise & ~key_prev;
        key_idx = lowest_index(key_act);
        cmd_idx = lowest_index(cmd_act);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            code_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            type_q     <= '0;
            evt_code_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|cmd_act) begin
                        case (cmd_idx)
                            CMD_ENTER: begin
                                if (cnt_q != '0) begin
                                    evt_code_q <= code_q;
                                    type_q     <= EVT_ENTER;
                                    valid_q    <= 1'b1;
                                    state_q    <= ST_HOLD;
                                    code_q     <= '0;
                                    cnt_q      <= '0;
                                    cur_q      <= '0;
                                end
                            end
                            CMD_PAY: begin
                                evt_code_q <= '0;
                                type_q     <= EVT_PAY;
                                valid_q    <= 1'b1;
                                state_q    <= ST_HOLD;
                            end
                            default: begin
                                // CANCEL and CLEAR_SALE both abandon the entry.
                                evt_code_q <= '0;
                                type_q     <= (cmd_idx == CMD_CANCEL) ? EVT_CANCEL : EVT_CLEAR_SALE;
                                valid_q    <= 1'b1;
                                state_q    <= ST_HOLD;
                                code_q     <= '0;
                                cnt_q      <= '0;
                                cur_q      <= '0;
                            end
                        endcase
                    end else if (|key_act) begin
                        case (key_idx)
                            KEY_UP:   cur_q <= bcd_up(cur_q);
                            KEY_DOWN: cur_q <= bcd_down(cur_q);
                            KEY_COMMIT: begin
                                if (cnt_q != CNT_FULL) begin
                                    code_q <= (code_q << 4) | CODE_W'(cur_q);
                                    cnt_q  <= cnt_q + CW'(1);
                                    cur_q  <= '0;
                                end
                            end
                            default: begin
                                if (cnt_q != '0) begin
                                    code_q <= code_q >> 4;
                                    cnt_q  <= cnt_q - CW'(1);
                                end
                                cur_q <= '0;
                            end
                        endcase
                    end
                end
                default: begin
                    if (EVT_READY) begin
                        valid_q    <= 1'b0;
                        evt_code_q <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign CUR_DIGIT = cur_q;
    assign CODE      = code_q;
    assign DIGIT_CNT = cnt_q;
    assign EVT_VALID = valid_q;
    assign EVT_TYPE  = type_q;
    assign EVT_CODE  = evt_code_q;

endmodule

// File: tb/tb_key_entry_decoder.sv
// tb/tb_key_entry_decoder.sv - directed and random checks of key_entry_decoder against a digit-queue model
module tb_key_entry_decoder;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [3:0]  KEY_Reg;
    logic [3:0]  CMD_Reg;
    logic [3:0]  CUR_DIGIT;
    logic [11:0] CODE;
    logic [1:0]  DIGIT_CNT;
    logic        EVT_VALID;
    logic [1:0]  EVT_TYPE;
    logic [11:0] EVT_CODE;
    logic        EVT_READY;

    key_entry_decoder #(.DIGITS(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .KEY_Reg   (KEY_Reg),
        .CMD_Reg   (CMD_Reg),
        .CUR_DIGIT (CUR_DIGIT),
        .CODE      (CODE),
        .DIGIT_CNT (DIGIT_CNT),
        .EVT_VALID (EVT_VALID),
        .EVT_TYPE  (EVT_TYPE),
        .EVT_CODE  (EVT_CODE),
        .EVT_READY (EVT_READY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    int   m_cur;
    int   m_q[$];
    bit   m_valid;
    int   m_type;
    int   m_code;
    logic [3:0] s_k, p_k, s_c, p_c;

    int vcount;
    int last_type;
    int last_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pack_code();
        int c = 0;
        foreach (m_q[i]) c = c * 16 + m_q[i];
        return c;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_q.delete(); m_valid = 0; m_type = 0; m_code = 0;
        s_k = 0; p_k = 0; s_c = 0; p_c = 0;
    endtask

    task automatic model_edge(input logic [3:0] k, input logic [3:0] c, input bit r);
        logic [3:0] kp, cp;
        int i;
        if (m_valid) begin
            if (r) begin m_valid = 0; m_code = 0; end
        end else begin
            kp = s_k & ~p_k & ~p_c;
            cp = s_c & ~p_c & ~p_k;
            if (cp != 0) begin
                i = 0;
                for (int b = 3; b >= 0; b--) if (cp[b]) i = b;
                if (i == 0) begin
                    if (m_q.size() > 0) begin
                        m_code = pack_code(); m_type = 0; m_valid = 1;
                        m_q.delete(); m_cur = 0;
                    end
                end else begin
                    m_code = 0; m_type = i; m_valid = 1;
                    if (i != 2) begin m_q.delete(); m_cur = 0; end
                end
            end else if (kp != 0) begin
                i = 0;
                for (int b = 3; b >= 0; b--) if (kp[b]) i = b;
                case (i)
                    0: m_cur = (m_cur + 1) % 10;
                    1: m_cur = (m_cur + 9) % 10;
                    2: if (m_q.size() < 3) begin m_q.push_back(m_cur); m_cur = 0; end
                    default: begin
                        if (m_q.size() > 0) void'(m_q.pop_back());
                        m_cur = 0;
                    end
                endcase
            end
        end
        p_k = s_k; s_k = k; p_c = s_c; s_c = c;
    endtask

    task automatic check_all();
        chk("cur_digit", 32'(CUR_DIGIT), m_cur);
        chk("code",      32'(CODE),      pack_code());
        chk("digit_cnt", 32'(DIGIT_CNT), m_q.size());
        chk("evt_valid", 32'(EVT_VALID), 32'(m_valid));
        chk("evt_type",  32'(EVT_TYPE),  m_type);
        chk("evt_code",  32'(EVT_CODE),  m_code);
    endtask

    task automatic cyc(input logic [3:0] k, input logic [3:0] c, input bit r);
        KEY_Reg = k; CMD_Reg = c; EVT_READY = r;
        @(posedge CLOCK_50);
        model_edge(k, c, r);
        #1;
        check_all();
        if (EVT_VALID === 1'b1) begin
            vcount++;
            last_type = EVT_TYPE;
            last_code = EVT_CODE;
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [3:0] c, input bit r);
        cyc(k, c, r);
        cyc(4'h0, 4'h0, r);
    endtask

    task automatic press_n(input logic [3:0] k, input int n);
        for (int j = 0; j < n; j++) press(k, 4'h0, 1'b1);
    endtask

    initial begin
        RESET = 1'b1; KEY_Reg = 0; CMD_Reg = 0; EVT_READY = 0;
        model_reset();
        #1;
        chk("reset_cur", 32'(CUR_DIGIT), 0);
        chk("reset_code", 32'(CODE), 0);
        chk("reset_cnt", 32'(DIGIT_CNT), 0);
        chk("reset_valid", 32'(EVT_VALID), 0);
        chk("reset_evt_code", 32'(EVT_CODE), 0);
        repeat (2) @(posedge CLOCK_50);
        #3 RESET = 1'b0;

        // Up-count wrap
        press_n(4'b0001, 11);
        chk("up_wrap", 32'(CUR_DIGIT), 1);
        press_n(4'b0010, 2);
        chk("down_wrap", 32'(CUR_DIGIT), 9);
        press_n(4'b1000, 1);
        chk("back_empty_cur", 32'(CUR_DIGIT), 0);

        // Entry 4,0,7 then ENTER
        press_n(4'b0001, 4); press_n(4'b0100, 1);
        press_n(4'b0100, 1);
        press_n(4'b0001, 7); press_n(4'b0100, 1);
        chk("entry_code", 32'(CODE), 32'h407);
        vcount = 0;
        press(4'h0, 4'b0001, 1'b1);
        repeat (3) cyc(4'h0, 4'h0, 1'b1);
        chk("enter_pulses", vcount, 1);
        chk("enter_type", last_type, 0);
        chk("enter_code", last_code, 32'h407);
        chk("enter_clr_code", 32'(CODE), 0);
        chk("enter_clr_cnt", 32'(DIGIT_CNT), 0);

        // Full code and backspace
        press_n(4'b0001, 1); press_n(4'b0100, 1);
        press_n(4'b0001, 2); press_n(4'b0100, 1);
        press_n(4'b0001, 3); press_n(4'b0100, 1);
        press_n(4'b0001, 1); press_n(4'b0100, 1);
        chk("full_code", 32'(CODE), 32'h123);
        chk("full_cnt", 32'(DIGIT_CNT), 3);
        press_n(4'b1000, 1);
        chk("back_code", 32'(CODE), 32'h012);
        chk("back_cnt", 32'(DIGIT_CNT), 2);
        press_n(4'b1000, 2);
        vcount = 0;
        press(4'h0, 4'b0001, 1'b1);
        repeat (3) cyc(4'h0, 4'h0, 1'b1);
        chk("enter_empty", vcount, 0);

        // Backpressure on PAY
        press_n(4'b0001, 2); press_n(4'b0100, 1);
        vcount = 0;
        press(4'h0, 4'b0100, 1'b0);
        repeat (20) cyc(4'h0, 4'h0, 1'b0);
        press(4'h0, 4'b0010, 1'b0);
        chk("pay_hold_type", 32'(EVT_TYPE), 2);
        cyc(4'h0, 4'h0, 1'b1);
        chk("pay_released", 32'(EVT_VALID), 0);
        repeat (4) cyc(4'h0, 4'h0, 1'b1);
        chk("pay_valid_cycles", vcount, 23);
        chk("pay_keeps_code", 32'(CODE), 32'h2);
        chk("pay_keeps_cnt", 32'(DIGIT_CNT), 1);

        // Simultaneous commands and mode switch
        vcount = 0;
        press(4'h0, 4'b0110, 1'b1);
        repeat (2) cyc(4'h0, 4'h0, 1'b1);
        chk("simul_count", vcount, 1);
        chk("simul_type", last_type, 1);
        cyc(4'b0001, 4'h0, 1'b1);
        cyc(4'h0, 4'b0001, 1'b1);
        chk("switch_key_press", 32'(CUR_DIGIT), 1);
        vcount = 0;
        repeat (3) cyc(4'h0, 4'b0001, 1'b1);
        repeat (2) cyc(4'h0, 4'h0, 1'b1);
        chk("switch_no_event", vcount, 0);
        chk("switch_cur_kept", 32'(CUR_DIGIT), 1);

        // Reset while an event is pending
        press(4'h0, 4'b0100, 1'b0);
        chk("pre_reset_valid", 32'(EVT_VALID), 1);
        RESET = 1'b1;
        #2;
        chk("async_rst_valid", 32'(EVT_VALID), 0);
        chk("async_rst_cur", 32'(CUR_DIGIT), 0);
        chk("async_rst_code", 32'(CODE), 0);
        model_reset();
        @(negedge CLOCK_50);
        RESET = 1'b0;
        vcount = 0;
        repeat (5) cyc(4'h0, 4'h0, 1'b1);
        chk("no_replay", vcount, 0);

        // Random levels and backpressure
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] rk, rc;
            rk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rc = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cyc(rk, rc, $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
